// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the MEM-stage data-memory responder.
package dmem_responder_pkg;

    localparam int WORD_W          = 32;
    localparam int DEPTH_DEF       = 256;
    localparam int WAIT_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-wide SRAM: synchronous write, registered read that holds between reads.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[idx] <= wdata;
        if (re) rdata_q <= mem_q[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a MEM-stage request, inserts wait states,
// commits the access on the edge leaving DONE and stalls the pipeline until then.
//   state | meaning
//   IDLE  | no access in flight; a request is latched here
//   WAIT  | counting down wait states; dropping the request flushes it
//   DONE  | stall released; access commits on the closing edge
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              stall,
    output logic              resp_valid,
    output logic              err
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic              conflict_q, conflict_d;
    logic              resp_valid_q, resp_valid_d;
    logic              err_q, err_d;
    logic              rd_hit_q, rd_hit_d;

    logic              req;
    logic              bad_addr;
    logic              arr_we;
    logic              arr_re;
    logic [WORD_W-1:0] arr_rdata;

    assign req      = MemRead | MemWrite;
    assign bad_addr = (|addr_q[1:0]) | (|addr_q[WORD_W-1:AW+2]);
    assign arr_we   = (state_q == DONE) & is_wr_q & ~bad_addr;
    assign arr_re   = (state_q == DONE) & ~is_wr_q & ~bad_addr;
    assign stall    = req & (state_q != DONE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        is_wr_d      = is_wr_q;
        conflict_d   = conflict_q;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        rd_hit_d     = rd_hit_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d     = addr;
                    wdata_d    = wdata;
                    is_wr_d    = MemWrite;
                    conflict_d = MemRead & MemWrite;
                    cnt_d      = WAIT_LD;
                    state_d    = (WAIT_CYCLES > 0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = DONE;
                end
            end
            DONE: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                err_d        = bad_addr | conflict_q;
                // a failed read forces rdata to zero; writes leave it alone
                if (!is_wr_q) rd_hit_d = ~bad_addr;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            is_wr_q      <= 1'b0;
            conflict_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rd_hit_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            is_wr_q      <= is_wr_d;
            conflict_q   <= conflict_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            rd_hit_q     <= rd_hit_d;
        end
    end

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign rdata      = rd_hit_q ? arr_rdata : '0;
    assign resp_valid = resp_valid_q;
    assign err        = err_q;

endmodule
